// File: rtl/div_iter_if.sv
// Divide request/response bundle between the E-stage pipeline (master) and
// the iterative divider (slave).
interface div_iter_if #(parameter int WIDTH = 32);
    logic             div;
    logic             div_signed;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             div_complete;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output div, div_signed, src_a, src_b, cancel,
        input  div_complete, busy, hi, lo
    );

    modport slave (
        input  div, div_signed, src_a, src_b, cancel,
        output div_complete, busy, hi, lo
    );
endinterface

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// WIDTH+1 cycles from start to the div_complete pulse that releases the stall.
module div_iter #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    div_iter_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_qNeg;
    logic             r_rNeg;
    logic             r_divZero;
    logic             r_busy;
    logic [WIDTH-1:0] r_resHi;
    logic [WIDTH-1:0] r_resLo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_aNeg;
    logic             w_bNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic [WIDTH-1:0] w_fixRem;
    logic [WIDTH-1:0] w_fixQuo;

    assign w_aNeg = bus.div_signed & bus.src_a[WIDTH-1];
    assign w_bNeg = bus.div_signed & bus.src_b[WIDTH-1];
    assign w_absA = w_aNeg ? (~bus.src_a + 1'b1) : bus.src_a;
    assign w_absB = w_bNeg ? (~bus.src_b + 1'b1) : bus.src_b;

    // The dividend lives in r_quo and is shifted out of its MSB into the
    // remainder one bit per step; the trial needs one extra bit of headroom.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, r_dvsr};
    assign w_ge      = (w_trial >= {1'b0, r_dvsr});
    assign w_remNext = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quoNext = {r_quo[WIDTH-2:0], w_ge};

    // Divide-by-zero leaves |a| in the remainder, so only the quotient is forced.
    assign w_fixRem = r_rNeg ? (~w_remNext + 1'b1) : w_remNext;
    assign w_fixQuo = r_divZero ? {WIDTH{1'b1}}
                    : (r_qNeg ? (~w_quoNext + 1'b1) : w_quoNext);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_qNeg    <= 1'b0;
            r_rNeg    <= 1'b0;
            r_divZero <= 1'b0;
            r_busy    <= 1'b0;
            r_resHi   <= '0;
            r_resLo   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.div && !bus.cancel) begin
                        r_rem     <= '0;
                        r_quo     <= w_absA;
                        r_dvsr    <= w_absB;
                        r_qNeg    <= w_aNeg ^ w_bNeg;
                        r_rNeg    <= w_aNeg;
                        r_divZero <= (bus.src_b == '0);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.cancel) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_remNext;
                        r_quo <= w_quoNext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_STEP) begin
                            r_resHi <= w_fixRem;
                            r_resLo <= w_fixQuo;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // A flush landing on the completion cycle discards the result.
                    if (!bus.cancel) begin
                        r_hi <= r_resHi;
                        r_lo <= r_resLo;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_complete = (r_state == S_DONE) & ~bus.cancel;
    assign bus.busy         = r_busy;
    assign bus.hi           = (r_state == S_DONE) ? r_resHi : r_hi;
    assign bus.lo           = (r_state == S_DONE) ? r_resLo : r_lo;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed divides push expected HI/LO and
// completion cycle; a negedge monitor pops and compares on each pulse.
module tb_div_iter;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cycleCount;
    int   nChecks;
    int   nPass;
    int   busyCnt;
    exp_t sbQ[$];

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) busyCnt++;
        else busyCnt = 0;
        if (bus.div_complete === 1'b1) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_pulse: got div_complete=1 at cycle %0d expected none", cycleCount);
            end else begin
                e = sbQ.pop_front();
                checkOutput("lo", bus.lo, e.lo);
                checkOutput("hi", bus.hi, e.hi);
                checkOutput("latency", W'(cycleCount), W'(e.cyc));
                checkOutput("busy_cycles", W'(busyCnt), W'(W + 1));
            end
        end
    end

    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] eh, input logic [W-1:0] el, input bit expectDone);
        exp_t e;
        @(negedge clk);
        bus.div_signed = sgn;
        bus.src_a      = a;
        bus.src_b      = b;
        bus.div        = 1'b1;
        if (expectDone) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = cycleCount + W + 1;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitDone(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < W + 8 && !seen; i++) begin
            @(negedge clk);
            if (bus.div_complete === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            nChecks++;
            $display("[TB] FAIL timeout_%s: got no div_complete expected a pulse", name);
        end
    endtask

    task automatic runDivide(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
        applyStimulus(sgn, a, b, eh, el, 1'b1);
        waitDone(name);
        bus.div = 1'b0;
    endtask

    initial begin
        exp_t e;
        nChecks    = 0;
        nPass      = 0;
        busyCnt    = 0;
        cycleCount = 0;
        reset          = 1'b0;
        bus.div        = 1'b0;
        bus.div_signed = 1'b0;
        bus.src_a      = '0;
        bus.src_b      = '0;
        bus.cancel     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_hi", bus.hi, '0);
        checkOutput("rst_lo", bus.lo, '0);
        checkOutput("rst_complete", W'(bus.div_complete), '0);
        checkOutput("rst_busy", W'(bus.busy), '0);
        reset = 1'b1;

        runDivide(1'b0, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
        runDivide(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        runDivide(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_7_m2");
        runDivide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");
        runDivide(1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "divu_by0");
        runDivide(1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_by0");

        // Flush mid-run: no pulse, results from the previous divide persist.
        applyStimulus(1'b0, 32'd100, 32'd7, '0, '0, 1'b0);
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        bus.div    = 1'b0;
        @(negedge clk);
        bus.cancel = 1'b0;
        checkOutput("cancel_busy", W'(bus.busy), '0);
        repeat (W + 8) @(negedge clk);
        checkOutput("cancel_hi", bus.hi, 32'hFFFF_FFF9);
        checkOutput("cancel_lo", bus.lo, 32'hFFFF_FFFF);

        @(negedge clk);
        bus.div    = 1'b1;
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.div    = 1'b0;
        bus.cancel = 1'b0;
        checkOutput("idle_cancel_busy", W'(bus.busy), '0);

        runDivide(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

        // Asynchronous reset in the middle of a run.
        applyStimulus(1'b0, 32'd100, 32'd7, '0, '0, 1'b0);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_hi", bus.hi, '0);
        checkOutput("async_lo", bus.lo, '0);
        checkOutput("async_busy", W'(bus.busy), '0);
        checkOutput("async_complete", W'(bus.div_complete), '0);
        bus.div = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (W + 8) @(negedge clk);

        // Back-to-back: div stays high through the IDLE cycle after DONE.
        applyStimulus(1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b1);
        waitDone("b2b_first");
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'h10;
        e.hi  = 32'hF;
        e.lo  = 32'h0FFF_FFFF;
        e.cyc = cycleCount + W + 2;
        sbQ.push_back(e);
        waitDone("b2b_second");
        bus.div = 1'b0;

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", W'(sbQ.size()), '0);

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
